// File: rtl/pipe_fetch_if.sv
// Bundle between pipe_fetch and the rest of the pipeline: imem load port, M/W redirect inputs, stall/bubble control, D outputs.
// FETCH_PERF_CNT_EN adds the perf_fetched/perf_bubbles counter outputs.
interface pipe_fetch_if;
  logic        imem_we;
  logic [63:0] imem_waddr;
  logic [7:0]  imem_wdata;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic        F_stall;
  logic        D_stall;
  logic        D_bubble;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode;
  logic [3:0]  D_ifun;
  logic [3:0]  D_rA;
  logic [3:0]  D_rB;
  logic [63:0] D_valC;
  logic [63:0] D_valP;
  logic [63:0] f_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  modport slave (
    input  imem_we, imem_waddr, imem_wdata, M_icode, M_Cnd, M_valA, W_icode, W_valM,
    input  F_stall, D_stall, D_bubble,
    output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, f_pc
`ifdef FETCH_PERF_CNT_EN
    , output perf_fetched, perf_bubbles
`endif
  );

  modport master (
    output imem_we, imem_waddr, imem_wdata, M_icode, M_Cnd, M_valA, W_icode, W_valM,
    output F_stall, D_stall, D_bubble,
    input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, f_pc
`ifdef FETCH_PERF_CNT_EN
    , input perf_fetched, perf_bubbles
`endif
  );
endinterface

// File: rtl/pipe_fetch.sv
// Y86-64 fetch stage with F/D registers: fetch in cycle n lands on D after edge n+1; F_stall/D_stall hold, D_bubble loads a NOP.
// Optional FETCH_PERF_CNT_EN adds 32-bit fetched/bubble counters.
module pipe_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        res,
  pipe_fetch_if.slave fif
);
  localparam int          AW        = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam logic [63:0] MEM_LIMIT = 64'(IMEM_BYTES);

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } d_reg_t;

  localparam d_reg_t D_BUBBLE = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF,
                                  valc: 64'h0, valp: 64'h0};

  logic [7:0]  imem [IMEM_BYTES];
  logic [63:0] f_pred_pc_q, f_pred_pc_d;
  logic [63:0] f_pc;
  logic [63:0] pred_pc;
  d_reg_t      d_q, d_d, f_instr;
  logic [7:0]  fbyte [10];
  logic [9:0]  byte_ok;
  logic [3:0]  raw_icode;
  logic [3:0]  ilen;
  logic        need_regids, need_valc, imem_error, instr_valid;

  always_ff @(posedge clk) begin
    if (fif.imem_we && (fif.imem_waddr < MEM_LIMIT))
      imem[fif.imem_waddr[AW-1:0]] <= fif.imem_wdata;
  end

  always_comb begin
    f_pc = f_pred_pc_q;
    if (fif.M_icode == 4'h7 && !fif.M_Cnd)
      f_pc = fif.M_valA;
    else if (fif.W_icode == 4'h9)
      f_pc = fif.W_valM;
  end

  // Out-of-range bytes read as zero; whether they matter is decided by the parsed length.
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      byte_ok[i] = (f_pc + 64'(i)) < MEM_LIMIT;
      fbyte[i]   = byte_ok[i] ? imem[AW'(f_pc + 64'(i))] : 8'h00;
    end
  end

  always_comb begin
    f_instr     = D_BUBBLE;
    raw_icode   = fbyte[0][7:4];
    need_regids = raw_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    need_valc   = raw_icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    ilen        = 4'd1 + {3'd0, need_regids} + (need_valc ? 4'd8 : 4'd0);
    imem_error  = 1'b0;
    for (int i = 0; i < 10; i++)
      if ((4'(i) < ilen) && !byte_ok[i])
        imem_error = 1'b1;
    f_instr.icode = imem_error ? 4'h1 : raw_icode;
    f_instr.ifun  = imem_error ? 4'h0 : fbyte[0][3:0];
    f_instr.ra    = need_regids ? fbyte[1][7:4] : 4'hF;
    f_instr.rb    = need_regids ? fbyte[1][3:0] : 4'hF;
    f_instr.valc  = 64'h0;
    if (need_valc)
      f_instr.valc = need_regids
        ? {fbyte[9], fbyte[8], fbyte[7], fbyte[6], fbyte[5], fbyte[4], fbyte[3], fbyte[2]}
        : {fbyte[8], fbyte[7], fbyte[6], fbyte[5], fbyte[4], fbyte[3], fbyte[2], fbyte[1]};
    f_instr.valp = f_pc + 64'(ilen);
    instr_valid  = f_instr.icode <= 4'hB;
    if (imem_error)
      f_instr.stat = 3'd3;
    else if (!instr_valid)
      f_instr.stat = 3'd4;
    else if (f_instr.icode == 4'h0)
      f_instr.stat = 3'd2;
    else
      f_instr.stat = 3'd1;
    pred_pc = (f_instr.icode == 4'h7 || f_instr.icode == 4'h8) ? f_instr.valc : f_instr.valp;
  end

  always_comb begin
    f_pred_pc_d = fif.F_stall ? f_pred_pc_q : pred_pc;
    d_d         = f_instr;
    if (fif.D_stall)
      d_d = d_q;
    else if (fif.D_bubble)
      d_d = D_BUBBLE;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      f_pred_pc_q <= RESET_PC;
      d_q         <= D_BUBBLE;
    end else begin
      f_pred_pc_q <= f_pred_pc_d;
      d_q         <= d_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_bubbles_q, perf_bubbles_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (!fif.D_stall) begin
      if (fif.D_bubble)
        perf_bubbles_d = perf_bubbles_q + 32'd1;
      else
        perf_fetched_d = perf_fetched_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      perf_fetched_q <= 32'd0;
      perf_bubbles_q <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign fif.perf_fetched = perf_fetched_q;
  assign fif.perf_bubbles = perf_bubbles_q;
`endif

  assign fif.D_stat  = d_q.stat;
  assign fif.D_icode = d_q.icode;
  assign fif.D_ifun  = d_q.ifun;
  assign fif.D_rA    = d_q.ra;
  assign fif.D_rB    = d_q.rb;
  assign fif.D_valC  = d_q.valc;
  assign fif.D_valP  = d_q.valp;
  assign fif.f_pc    = f_pc;
endmodule

// File: tb/tb_pipe_fetch.sv
// Directed bench for pipe_fetch: vector table of fetches at redirected PCs plus hand-written redirect/stall/reset sequences.
module tb_pipe_fetch;
  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  pipe_fetch_if fif();

  pipe_fetch #(.RESET_PC(64'h0), .IMEM_BYTES(1024)) dut (
    .clk (clk),
    .res (res),
    .fif (fif)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] pc;
    bit          full;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [63:0] pred;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_d(input string t, input logic [2:0] st, input logic [3:0] ic, input logic [3:0] ifn,
                       input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc,
                       input logic [63:0] vp, input bit full);
    chk($sformatf("%s.stat", t), 64'(fif.D_stat), 64'(st));
    chk($sformatf("%s.icode", t), 64'(fif.D_icode), 64'(ic));
    chk($sformatf("%s.ifun", t), 64'(fif.D_ifun), 64'(ifn));
    chk($sformatf("%s.valP", t), fif.D_valP, vp);
    if (full) begin
      chk($sformatf("%s.rA", t), 64'(fif.D_rA), 64'(ra));
      chk($sformatf("%s.rB", t), 64'(fif.D_rB), 64'(rb));
      chk($sformatf("%s.valC", t), fif.D_valC, vc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [63:0] a, input logic [7:0] d);
    fif.imem_we    = 1'b1;
    fif.imem_waddr = a;
    fif.imem_wdata = d;
    step();
    fif.imem_we    = 1'b0;
  endtask

  task automatic wr_instr(input logic [63:0] a, input int n, input logic [79:0] b);
    for (int i = 0; i < n; i++)
      wr(a + 64'(i), b[8*i +: 8]);
  endtask

  task automatic redirect(input logic [63:0] pc);
    fif.M_icode = 4'h7;
    fif.M_Cnd   = 1'b0;
    fif.M_valA  = pc;
  endtask

  task automatic idle_mw();
    fif.M_icode = 4'h0;
    fif.M_Cnd   = 1'b0;
    fif.M_valA  = 64'h0;
    fif.W_icode = 4'h0;
    fif.W_valM  = 64'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{64'h00,  1'b1, 3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'h0A, 64'h0A};
    vt[1]  = '{64'h0A,  1'b1, 3'd1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h0C, 64'h0C};
    vt[2]  = '{64'h0C,  1'b1, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0D, 64'h0D};
    vt[3]  = '{64'h0D,  1'b1, 3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0E, 64'h0E};
    vt[4]  = '{64'h0E,  1'b1, 3'd4, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0F, 64'h0F};
    vt[5]  = '{64'h20,  1'b1, 3'd1, 4'h7, 4'h1, 4'hF, 4'hF, 64'h100, 64'h29, 64'h100};
    vt[6]  = '{64'h30,  1'b1, 3'd1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h200, 64'h39, 64'h200};
    vt[7]  = '{64'h40,  1'b1, 3'd1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41, 64'h41};
    vt[8]  = '{64'h50,  1'b1, 3'd1, 4'h5, 4'h0, 4'h1, 4'h5, 64'h1122334455667788, 64'h5A, 64'h5A};
    vt[9]  = '{64'h60,  1'b1, 3'd4, 4'hF, 4'h0, 4'hF, 4'hF, 64'h0, 64'h61, 64'h61};
    vt[10] = '{64'h61,  1'b1, 3'd1, 4'h2, 4'h1, 4'h4, 4'h5, 64'h0, 64'h63, 64'h63};
    vt[11] = '{64'h70,  1'b1, 3'd1, 4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 64'h72, 64'h72};
    vt[12] = '{64'h72,  1'b1, 3'd1, 4'hB, 4'h0, 4'h4, 4'hF, 64'h0, 64'h74, 64'h74};
    vt[13] = '{64'h74,  1'b1, 3'd1, 4'h4, 4'h0, 4'h6, 4'h7, 64'h10, 64'h7E, 64'h7E};
    vt[14] = '{64'h3FE, 1'b1, 3'd1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h400, 64'h400};
    vt[15] = '{64'h3F8, 1'b0, 3'd3, 4'h1, 4'h0, 4'hF, 4'h2, 64'h0, 64'h402, 64'h402};
    vt[16] = '{64'h400, 1'b0, 3'd3, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h401, 64'h401};
    vt[17] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd3, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0};

    res = 1'b0;
    fif.imem_we = 1'b0; fif.imem_waddr = 64'h0; fif.imem_wdata = 8'h0;
    fif.F_stall = 1'b0; fif.D_stall = 1'b0; fif.D_bubble = 1'b0;
    idle_mw();
    step();
    step();

    // Program image, loaded while the pipeline is held in reset.
    wr_instr(64'h00,  10, 80'h0000_0000_0000_000A_F230);
    wr_instr(64'h0A,  2,  80'h2360);
    wr_instr(64'h0C,  3,  80'hC0_0010);
    wr_instr(64'h20,  9,  80'h0000_0000_0000_0001_0071);
    wr_instr(64'h30,  9,  80'h0000_0000_0000_0002_0080);
    wr_instr(64'h40,  1,  80'h90);
    wr_instr(64'h50,  10, 80'h1122_3344_5566_7788_1550);
    wr_instr(64'h60,  3,  80'h45_21F0);
    wr_instr(64'h70,  4,  80'h4FB0_3FA0);
    wr_instr(64'h74,  10, 80'h0000_0000_0000_0010_6740);
    wr_instr(64'h3F8, 6,  80'h0000_0000_F230);
    wr_instr(64'h3FE, 2,  80'h2360);
    wr(64'h400, 8'hFF);

    chk_d("reset", 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b1);
    chk("reset.f_pc", fif.f_pc, 64'h0);

    res = 1'b1;
    step();
    chk_d("first", 3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'h0A, 1'b1);
    chk("first.f_pc", fif.f_pc, 64'h0A);

    for (int i = 0; i < 18; i++) begin
      redirect(vt[i].pc);
      #1;
      chk($sformatf("vec%0d.f_pc", i), fif.f_pc, vt[i].pc);
      step();
      idle_mw();
      #1;
      chk_d($sformatf("vec%0d", i), vt[i].stat, vt[i].icode, vt[i].ifun, vt[i].ra, vt[i].rb,
            vt[i].valc, vt[i].valp, vt[i].full);
      chk($sformatf("vec%0d.pred", i), fif.f_pc, vt[i].pred);
    end

    // Predicted jump target, then the misprediction correction.
    redirect(64'h20);
    step();
    idle_mw();
    #1;
    chk("jmp.pred_f_pc", fif.f_pc, 64'h100);
    fif.M_icode = 4'h7; fif.M_Cnd = 1'b0; fif.M_valA = 64'h29;
    #1;
    chk("jmp.mispredict_f_pc", fif.f_pc, 64'h29);

    fif.W_icode = 4'h9; fif.W_valM = 64'h40; fif.M_valA = 64'h80;
    #1;
    chk("prio.mispredict_wins", fif.f_pc, 64'h80);
    fif.M_Cnd = 1'b1;
    #1;
    chk("prio.ret_when_taken", fif.f_pc, 64'h40);
    fif.W_icode = 4'h0;
    #1;
    chk("prio.predpc", fif.f_pc, 64'h100);
    idle_mw();

    // Stall and bubble interplay.
    redirect(64'h50);
    step();
    idle_mw();
    fif.F_stall = 1'b1; fif.D_stall = 1'b1;
    step();
    step();
    chk("stall.f_pc", fif.f_pc, 64'h5A);
    chk_d("stall", 3'd1, 4'h5, 4'h0, 4'h1, 4'h5, 64'h1122334455667788, 64'h5A, 1'b1);
    fif.D_bubble = 1'b1;
    step();
    chk_d("stall_bubble", 3'd1, 4'h5, 4'h0, 4'h1, 4'h5, 64'h1122334455667788, 64'h5A, 1'b1);
    fif.D_stall = 1'b0; fif.F_stall = 1'b0;
    step();
    chk_d("bubble", 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b1);
    fif.D_bubble = 1'b0;

    // Same-edge write to the byte being fetched: the fetch sees the old byte.
    redirect(64'h0C);
    fif.imem_we = 1'b1; fif.imem_waddr = 64'h0C; fif.imem_wdata = 8'h00;
    step();
    fif.imem_we = 1'b0;
    idle_mw();
    chk("rdw.old_icode", 64'(fif.D_icode), 64'h1);
    redirect(64'h0C);
    step();
    idle_mw();
    chk("rdw.new_icode", 64'(fif.D_icode), 64'h0);
    chk("rdw.new_stat", 64'(fif.D_stat), 64'h2);

    // Five sequential fetches from 0, then asynchronous reset between edges.
    redirect(64'h00);
    step();
    idle_mw();
    for (int i = 0; i < 4; i++) step();
    #1;
    res = 1'b0;
    #1;
    chk_d("async_rst", 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b1);
    chk("async_rst.f_pc", fif.f_pc, 64'h0);
    step();
    res = 1'b1;
`ifdef FETCH_PERF_CNT_EN
    chk("perf.fetched_rst", 64'(fif.perf_fetched), 64'd0);
    chk("perf.bubbles_rst", 64'(fif.perf_bubbles), 64'd0);
`endif
    step();
    chk_d("mem_kept", 3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'h0A, 1'b1);
    step();
    step();
    fif.D_bubble = 1'b1;
    step();
    fif.D_bubble = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    chk("perf.fetched", 64'(fif.perf_fetched), 64'd3);
    chk("perf.bubbles", 64'(fif.perf_bubbles), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
